mem_bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the core's single memory port.
- Masters: instruction fetch (IFU) and load/store (LSU, fed by the execute stage's mem_ren/mem_wen/addr/wdata/wmask).
- Holds at most one transaction in flight and routes each response back to the master that issued it.
- Sits between the IFU/LSU stages and the memory interconnect.

---
 rtl/mem_bus_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// ---------------
// Two-master / one-slave arbiter for the core's single memory port. The
// instruction fetch unit (IFU) and the load/store unit (LSU) compete for the
// bus. Only one transaction is in flight at a time. Each response is routed
// back to the master that issued the request.
//
// Optional feature (macro ARB_ROUND_ROBIN_EN):
//   undefined - fixed priority: the LSU wins simultaneous requests.
//   defined   - a last-owner register alternates simultaneous requests
//               between the two masters.
//
// Ports:
//   i_clock, i_reset         clock; synchronous active-high reset
//   i_ifu_req/addr/cancel    fetch request, address, pipeline flush
//   o_ifu_gnt/rvalid/rdata/err  fetch grant pulse and response
//   i_lsu_req/wen/addr/wdata/wmask  load/store request
//   o_lsu_gnt/rvalid/rdata/err  load/store grant pulse and response
//   o_bus_req/wen/addr/wdata/wmask  request to the slave
//   i_bus_ready              slave accepts the request
//   i_bus_rvalid/rdata/err   slave response
//   o_busy                   a transaction is in progress
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,

    input  logic                  i_ifu_req,
    input  logic [ADDR_W-1:0]     i_ifu_addr,
    input  logic                  i_ifu_cancel,
    output logic                  o_ifu_gnt,
    output logic                  o_ifu_rvalid,
    output logic [DATA_W-1:0]     o_ifu_rdata,
    output logic                  o_ifu_err,

    input  logic                  i_lsu_req,
    input  logic                  i_lsu_wen,
    input  logic [ADDR_W-1:0]     i_lsu_addr,
    input  logic [DATA_W-1:0]     i_lsu_wdata,
    input  logic [DATA_W/8-1:0]   i_lsu_wmask,
    output logic                  o_lsu_gnt,
    output logic                  o_lsu_rvalid,
    output logic [DATA_W-1:0]     o_lsu_rdata,
    output logic                  o_lsu_err,

    output logic                  o_bus_req,
    output logic                  o_bus_wen,
    output logic [ADDR_W-1:0]     o_bus_addr,
    output logic [DATA_W-1:0]     o_bus_wdata,
    output logic [DATA_W/8-1:0]   o_bus_wmask,
    input  logic                  i_bus_ready,
    input  logic                  i_bus_rvalid,
    input  logic [DATA_W-1:0]     i_bus_rdata,
    input  logic                  i_bus_err,

    output logic                  o_busy
);

    localparam int unsigned MASK_W = DATA_W / 8;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q;
    logic                wen_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MASK_W-1:0]   wmask_q;
    logic                drop_q, drop_d;

    logic                any_req;
    logic                lsu_wins;
    logic                grant;
    logic                resp_fire;
    logic                ifu_deliver;
    logic                lsu_deliver;

`ifdef ARB_ROUND_ROBIN_EN
    logic                last_q;
`endif

    // Arbitration: decides which requester wins when the bus is idle
    always_comb begin
        any_req  = i_ifu_req | i_lsu_req;
        lsu_wins = 1'b0;
        if (i_lsu_req && !i_ifu_req) begin
            lsu_wins = 1'b1;
        end else if (i_lsu_req && i_ifu_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            // Alternate: give the bus to whoever did not own the last grant
            lsu_wins = (last_q == OWN_IFU);
`else
            lsu_wins = 1'b1;
`endif
        end
        grant = (state_q == ST_IDLE) && any_req;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (any_req)      state_d = ST_REQ;
            ST_REQ:  if (i_bus_ready)  state_d = ST_RESP;
            ST_RESP: if (i_bus_rvalid) state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // Drop flag: a flush while the IFU owns the transaction discards its response
    always_comb begin
        drop_d = drop_q;
        if ((state_q == ST_REQ || state_q == ST_RESP) && owner_q == OWN_IFU && i_ifu_cancel) begin
            drop_d = 1'b1;
        end
        if (state_q == ST_RESP && i_bus_rvalid) begin
            drop_d = 1'b0;
        end
    end

    // State, drop flag and latched request fields
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_IFU;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            if (grant) begin
                if (lsu_wins) begin
                    owner_q <= OWN_LSU;
                    wen_q   <= i_lsu_wen;
                    addr_q  <= i_lsu_addr;
                    wdata_q <= i_lsu_wdata;
                    wmask_q <= i_lsu_wmask;
                end else begin
                    owner_q <= OWN_IFU;
                    wen_q   <= 1'b0;
                    addr_q  <= i_ifu_addr;
                    wdata_q <= '0;
                    wmask_q <= '0;
                end
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Last-owner register, updated on every grant
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            last_q <= OWN_IFU;
        end else if (grant) begin
            last_q <= lsu_wins ? OWN_LSU : OWN_IFU;
        end
    end
`endif

    // Grant pulses and response routing; a same-cycle flush also suppresses delivery
    always_comb begin
        o_ifu_gnt   = grant && !lsu_wins;
        o_lsu_gnt   = grant && lsu_wins;

        resp_fire   = (state_q == ST_RESP) && i_bus_rvalid;
        ifu_deliver = resp_fire && (owner_q == OWN_IFU) && !drop_q && !i_ifu_cancel;
        lsu_deliver = resp_fire && (owner_q == OWN_LSU);

        o_ifu_rvalid = ifu_deliver;
        o_ifu_rdata  = ifu_deliver ? i_bus_rdata : '0;
        o_ifu_err    = ifu_deliver && i_bus_err;
        o_lsu_rvalid = lsu_deliver;
        o_lsu_rdata  = lsu_deliver ? i_bus_rdata : '0;
        o_lsu_err    = lsu_deliver && i_bus_err;
    end

    // Bus request fields come only from the latched registers
    always_comb begin
        o_bus_req   = (state_q == ST_REQ);
        o_bus_wen   = o_bus_req && wen_q;
        o_bus_addr  = o_bus_req ? addr_q : '0;
        o_bus_wdata = (o_bus_req && wen_q) ? wdata_q : '0;
        o_bus_wmask = (o_bus_req && wen_q) ? wmask_q : '0;
        o_busy      = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized scoreboard bench for mem_bus_arbiter. The stimulus process plays
// both masters and the slave, keeps a transaction-level model and pushes the
// expected outputs of every cycle; a monitor pops and compares them.
module tb_mem_bus_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = DW / 8;
    localparam int NCYC = 4000;

    logic          clk;
    logic          rst;
    logic          ifu_req, ifu_cancel, ifu_gnt, ifu_rvalid, ifu_err;
    logic [AW-1:0] ifu_addr;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req, lsu_wen, lsu_gnt, lsu_rvalid, lsu_err;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata, lsu_rdata;
    logic [MW-1:0] lsu_wmask;
    logic          bus_req, bus_wen, bus_ready, bus_rvalid, bus_err, busy;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata, bus_rdata;
    logic [MW-1:0] bus_wmask;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_ifu_req(ifu_req), .i_ifu_addr(ifu_addr), .i_ifu_cancel(ifu_cancel),
        .o_ifu_gnt(ifu_gnt), .o_ifu_rvalid(ifu_rvalid), .o_ifu_rdata(ifu_rdata), .o_ifu_err(ifu_err),
        .i_lsu_req(lsu_req), .i_lsu_wen(lsu_wen), .i_lsu_addr(lsu_addr),
        .i_lsu_wdata(lsu_wdata), .i_lsu_wmask(lsu_wmask),
        .o_lsu_gnt(lsu_gnt), .o_lsu_rvalid(lsu_rvalid), .o_lsu_rdata(lsu_rdata), .o_lsu_err(lsu_err),
        .o_bus_req(bus_req), .o_bus_wen(bus_wen), .o_bus_addr(bus_addr),
        .o_bus_wdata(bus_wdata), .o_bus_wmask(bus_wmask),
        .i_bus_ready(bus_ready), .i_bus_rvalid(bus_rvalid), .i_bus_rdata(bus_rdata), .i_bus_err(bus_err),
        .o_busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit            skip;
        logic          gi, gl, breq, bwen, irv, ierr, lrv, lerr, busy;
        logic [AW-1:0] baddr;
        logic [DW-1:0] bwdata, irdata, lrdata;
        logic [MW-1:0] bwmask;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
        end
    endtask

    // Monitor: one expectation record per clock cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (!e.skip) begin
                    chk("ifu_gnt",    32'(ifu_gnt),    32'(e.gi));
                    chk("lsu_gnt",    32'(lsu_gnt),    32'(e.gl));
                    chk("bus_req",    32'(bus_req),    32'(e.breq));
                    chk("busy",       32'(busy),       32'(e.busy));
                    chk("ifu_rvalid", 32'(ifu_rvalid), 32'(e.irv));
                    chk("ifu_rdata",  32'(ifu_rdata),  32'(e.irdata));
                    chk("ifu_err",    32'(ifu_err),    32'(e.ierr));
                    chk("lsu_rvalid", 32'(lsu_rvalid), 32'(e.lrv));
                    chk("lsu_rdata",  32'(lsu_rdata),  32'(e.lrdata));
                    chk("lsu_err",    32'(lsu_err),    32'(e.lerr));
                    if (e.breq) begin
                        chk("bus_wen",   32'(bus_wen),   32'(e.bwen));
                        chk("bus_addr",  32'(bus_addr),  32'(e.baddr));
                        chk("bus_wdata", 32'(bus_wdata), 32'(e.bwdata));
                        chk("bus_wmask", 32'(bus_wmask), 32'(e.bwmask));
                    end
                end
            end
        end
    end

    // Model of the outstanding transaction (lifecycle: granted -> accepted -> answered)
    bit            m_busy, m_acc, m_lsu, m_wen, m_drop, rst_done;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [MW-1:0] m_wmask;
    int            m_cnt, m_dly_rdy, m_dly_rsp;
`ifdef ARB_ROUND_ROBIN_EN
    bit            m_last_lsu;
`endif
    // Requester state: a request stays pending until the model grants it
    bit            ifu_pend, lsu_pend;

    initial begin
        exp_t e;
        bit   do_rst, win_lsu;
        rst = 1'b1; ifu_req = 0; ifu_addr = '0; ifu_cancel = 0;
        lsu_req = 0; lsu_wen = 0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
        bus_ready = 0; bus_rvalid = 0; bus_rdata = '0; bus_err = 0;
        m_busy = 0; m_acc = 0; m_lsu = 0; m_drop = 0; rst_done = 0;
        ifu_pend = 0; lsu_pend = 0;
`ifdef ARB_ROUND_ROBIN_EN
        m_last_lsu = 0;
`endif
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            e = '{default: '0};
            do_rst = (c < 2) || (c >= NCYC / 2 && !rst_done && m_busy && !m_acc);
            if (do_rst) begin
                // Abandon everything; requests are withdrawn during reset
                if (c >= 2) rst_done = 1;
                rst = 1'b1;
                ifu_pend = 0; lsu_pend = 0;
                ifu_req = 0; lsu_req = 0; ifu_cancel = 0;
                bus_ready = 0; bus_rvalid = 0;
                m_busy = 0; m_acc = 0; m_drop = 0;
`ifdef ARB_ROUND_ROBIN_EN
                m_last_lsu = 0;
`endif
                e.skip = 1;
                exp_q.push_back(e);
                continue;
            end
            rst = 1'b0;

            if (!ifu_pend && $urandom_range(0, 99) < 40) begin
                ifu_pend = 1;
                ifu_addr = $urandom() & 32'hFFFF_FFFC;
            end
            if (!lsu_pend && $urandom_range(0, 99) < 35) begin
                lsu_pend  = 1;
                lsu_wen   = 1'($urandom_range(0, 1));
                lsu_addr  = $urandom() & 32'hFFFF_FFFC;
                lsu_wdata = $urandom();
                lsu_wmask = 4'($urandom_range(1, 15));
            end
            ifu_req    = ifu_pend;
            lsu_req    = lsu_pend;
            ifu_cancel = ($urandom_range(0, 99) < 10);
            bus_rdata  = $urandom();
            bus_err    = ($urandom_range(0, 7) == 0);
            bus_rvalid = 0;
            bus_ready  = (m_busy && !m_acc) ? (m_cnt == m_dly_rdy) : 1'($urandom_range(0, 1));
            if (m_busy && m_acc) bus_rvalid = (m_cnt == m_dly_rsp);

            // A flush during an IFU-owned transaction (after its grant cycle) drops the response
            if (m_busy && !m_lsu && ifu_cancel) m_drop = 1;

            e.busy = m_busy;
            if (!m_busy) begin
                if (ifu_pend || lsu_pend) begin
                    if (ifu_pend && lsu_pend) begin
`ifdef ARB_ROUND_ROBIN_EN
                        win_lsu = !m_last_lsu;
`else
                        win_lsu = 1;
`endif
                    end else begin
                        win_lsu = lsu_pend;
                    end
                    e.gl = win_lsu;
                    e.gi = !win_lsu;
`ifdef ARB_ROUND_ROBIN_EN
                    m_last_lsu = win_lsu;
`endif
                    m_busy = 1; m_acc = 0; m_cnt = 0; m_drop = 0;
                    m_dly_rdy = $urandom_range(0, 3);
                    m_dly_rsp = $urandom_range(0, 3);
                    m_lsu = win_lsu;
                    if (win_lsu) begin
                        m_wen   = lsu_wen;
                        m_addr  = lsu_addr;
                        m_wdata = lsu_wen ? lsu_wdata : '0;
                        m_wmask = lsu_wen ? lsu_wmask : '0;
                        lsu_pend = 0;
                    end else begin
                        m_wen = 0; m_addr = ifu_addr; m_wdata = '0; m_wmask = '0;
                        ifu_pend = 0;
                    end
                end
            end else if (!m_acc) begin
                e.breq = 1; e.bwen = m_wen; e.baddr = m_addr;
                e.bwdata = m_wdata; e.bwmask = m_wmask;
                if (bus_ready) begin
                    m_acc = 1; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end else begin
                if (bus_rvalid) begin
                    if (m_lsu) begin
                        e.lrv = 1; e.lrdata = bus_rdata; e.lerr = bus_err;
                    end else if (!m_drop) begin
                        e.irv = 1; e.irdata = bus_rdata; e.ierr = bus_err;
                    end
                    m_busy = 0; m_acc = 0; m_drop = 0;
                end else begin
                    m_cnt++;
                end
            end
            exp_q.push_back(e);
        end
        @(negedge clk);
        #1;
        if (!rst_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL mid_reset: reset in REQ never exercised");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
